// File: rtl/ram_burst_master.sv
// ram_burst_master: turns single write/read burst commands into beat-by-beat
// accesses on a synchronous single-port RAM. The burst address wraps at DEPTH.
// All outputs come from flops except cmd_ready and wr_ready, which are state
// decodes so a beat can be accepted the same cycle it is offered.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a command; cmd_ready high
// WR      | accepting write beats; each beat drives one RAM write next cycle
// WR_END  | last write on the RAM pins; done pulse follows
// RD_ADDR | read pins active, RAM samples the address at the end of this cycle
// RD_CAP  | RAM data valid; captured into rd_data at the end of this cycle
// RD_OUT  | rd_valid high, RAM idle, waiting for rd_ready
module ram_burst_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_END  = 3'd2,
    RD_ADDR = 3'd3,
    RD_CAP  = 3'd4,
    RD_OUT  = 3'd5
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d, addr_nxt;
  logic [LEN_WIDTH-1:0]  remaining, remaining_d;
  logic                  last_beat;

  logic                  busy_d, done_d, rd_valid_d;
  logic                  ram_cs_d, ram_we_d, ram_oe_d;
  logic [DATA_WIDTH-1:0] rd_data_d, ram_wdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WR);
  assign addr_nxt  = (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);
  assign last_beat = (remaining == LEN_WIDTH'(1));

  // Next-state and next-output decode; every registered output defaults to hold.
  always_comb begin
    state_d     = state;
    addr_d      = addr;
    remaining_d = remaining;
    busy_d      = busy;
    done_d      = 1'b0;
    rd_valid_d  = rd_valid;
    rd_data_d   = rd_data;
    ram_cs_d    = ram_cs;
    ram_we_d    = ram_we;
    ram_oe_d    = ram_oe;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            // Empty burst: acknowledge only, never touch the RAM.
            done_d = 1'b1;
          end else begin
            addr_d      = cmd_addr;
            remaining_d = cmd_len;
            busy_d      = 1'b1;
            if (cmd_write) begin
              state_d = WR;
            end else begin
              // Read pins go out with the state change so the RAM samples
              // them at the end of RD_ADDR.
              state_d    = RD_ADDR;
              ram_cs_d   = 1'b1;
              ram_we_d   = 1'b0;
              ram_oe_d   = 1'b1;
              ram_addr_d = cmd_addr;
            end
          end
        end
      end
      WR: begin
        if (wr_valid) begin
          ram_cs_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_oe_d    = 1'b0;
          ram_addr_d  = addr;
          ram_wdata_d = wr_data;
          addr_d      = addr_nxt;
          remaining_d = remaining - LEN_WIDTH'(1);
          if (last_beat) state_d = WR_END;
        end else begin
          ram_cs_d = 1'b0;
          ram_we_d = 1'b0;
        end
      end
      WR_END: begin
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      RD_ADDR: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        ram_cs_d   = 1'b0;
        ram_oe_d   = 1'b0;
        rd_data_d  = ram_rdata;
        rd_valid_d = 1'b1;
        state_d    = RD_OUT;
      end
      RD_OUT: begin
        if (rd_ready) begin
          rd_valid_d  = 1'b0;
          addr_d      = addr_nxt;
          remaining_d = remaining - LEN_WIDTH'(1);
          if (last_beat) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ram_cs_d   = 1'b1;
            ram_oe_d   = 1'b1;
            ram_addr_d = addr_nxt;
            state_d    = RD_ADDR;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, burst bookkeeping and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state     <= state_d;
      addr      <= addr_d;
      remaining <= remaining_d;
      busy      <= busy_d;
      done      <= done_d;
      rd_valid  <= rd_valid_d;
      rd_data   <= rd_data_d;
      ram_cs    <= ram_cs_d;
      ram_we    <= ram_we_d;
      ram_oe    <= ram_oe_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: synchronous RAM model, write/read scoreboards
// filled as stimulus is driven and drained by a negedge monitor.
module tb_ram_burst_master;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_cs, ram_we, ram_oe;
  wire  [DW-1:0] ram_rdata;

  ram_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // synchronous RAM: data valid the cycle after a read cycle, Z otherwise
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q;
  logic          ram_drv = 1'b0;
  assign ram_rdata = ram_drv ? ram_q : 'z;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_oe && !ram_we) begin
      ram_q   <= mem[ram_addr];
      ram_drv <= 1'b1;
    end else begin
      ram_drv <= 1'b0;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboards and bench-side memory image
  int            exp_wa [$];
  logic [DW-1:0] exp_wd [$];
  logic [DW-1:0] exp_rd [$];
  logic [DW-1:0] shadow [DEPTH];

  logic mon_en = 1'b0;
  int   n_writes = 0, n_reads = 0, done_cnt = 0, done_cyc = 0, n_rise = 0, last_hs = 0;
  int   wr_cyc [64];
  int   rise_cyc [64];
  logic rv_prev = 1'b0;
  int   acc_cyc = 0;

  // negedge monitor: drains scoreboards and logs event cycles
  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_cs && ram_we) begin
        wr_cyc[n_writes % 64] = cyc;
        n_writes++;
        if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_addr", 64'(ram_addr), 64'(exp_wa.pop_front()));
          chk("wr_data", 64'(ram_wdata), 64'(exp_wd.pop_front()));
        end
      end
      if (ram_cs && ram_oe && !ram_we) n_reads++;
      if (ram_we && ram_oe) chk("we_oe_excl", 1, 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", 64'(busy), 0);
      end
      if (rd_valid && !rv_prev) begin
        rise_cyc[n_rise % 64] = cyc;
        n_rise++;
      end
      rv_prev = rd_valid;
      if (rd_valid && rd_ready) begin
        last_hs = cyc;
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
      end
    end
  end

  task automatic do_cmd(input logic w, input int a, input int len);
    int guard = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = AW'(a); cmd_len = LW'(len);
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!cmd_ready) chk("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    acc_cyc = cyc - 1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int dc);
    int guard = 0;
    while (done_cnt <= dc && guard < 200) begin @(negedge clk); guard++; end
    if (done_cnt <= dc) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt - dc), 1);
    @(posedge clk); #1;
  endtask

  task automatic write_burst(input int a, input int len, input int gap_at, input int gap_len);
    logic [DW-1:0] dat [$];
    logic [DW-1:0] d;
    int i = 0, g = 0, guard = 0, base, dc;
    logic acc;
    for (int k = 0; k < len; k++) begin
      d = $urandom;
      dat.push_back(d);
      exp_wa.push_back((a + k) % DEPTH);
      exp_wd.push_back(d);
      shadow[(a + k) % DEPTH] = d;
    end
    base = n_writes; dc = done_cnt;
    do_cmd(1'b1, a, len);
    while (i < len && guard < 200) begin
      if (i == gap_at && g < gap_len) begin wr_valid = 1'b0; g++; end
      else begin wr_valid = 1'b1; wr_data = dat[i]; end
      @(negedge clk);
      acc = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    wr_valid = 1'b0;
    wait_done(dc);
    chk("wr_count", 64'(n_writes - base), 64'(len));
    chk("wr_first_lat", 64'(wr_cyc[base % 64] - acc_cyc), 2);
    chk("wr_span", 64'(wr_cyc[(base + len - 1) % 64] - wr_cyc[base % 64]), 64'(len - 1 + gap_len));
    chk("wr_done_lat", 64'(done_cyc - wr_cyc[(base + len - 1) % 64]), 1);
  endtask

  task automatic read_burst(input int a, input int len, input int stall);
    int base_r, base_n, dc, nr, guard = 0;
    for (int k = 0; k < len; k++) exp_rd.push_back(shadow[(a + k) % DEPTH]);
    base_r = n_rise; base_n = n_reads; dc = done_cnt;
    rd_ready = (stall == 0);
    do_cmd(1'b0, a, len);
    @(negedge clk);
    chk("rd_busy", 64'(busy), 1);
    if (stall > 0) begin
      while (!rd_valid && guard < 20) begin @(negedge clk); guard++; end
      nr = n_reads;
      repeat (stall) begin
        chk("stall_valid", 64'(rd_valid), 1);
        chk("stall_data", 64'(rd_data), 64'(exp_rd[0]));
        chk("stall_cs", 64'(ram_cs), 0);
        @(negedge clk);
      end
      chk("stall_no_read", 64'(n_reads - nr), 0);
      rd_ready = 1'b1;
    end
    wait_done(dc);
    rd_ready = 1'b0;
    chk("rd_beats", 64'(n_rise - base_r), 64'(len));
    chk("rd_latency", 64'(rise_cyc[base_r % 64] - acc_cyc), 3);
    chk("rd_ram_cycles", 64'(n_reads - base_n), 64'(2 * len));
    if (stall == 0 && len > 1)
      chk("rd_spacing", 64'(rise_cyc[(base_r + 1) % 64] - rise_cyc[base_r % 64]), 3);
    chk("rd_done_lat", 64'(done_cyc - last_hs), 1);
  endtask

  initial begin
    int nw, nr, dc;
    logic [DW-1:0] d0, d1;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin mem[k] = '0; shadow[k] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rd_valid", 64'(rd_valid), 0);
    chk("rst_rd_data", 64'(rd_data), 0);
    chk("rst_cs_we_oe", {61'd0, ram_cs, ram_we, ram_oe}, 0);
    chk("rst_ram_addr", 64'(ram_addr), 0);
    chk("rst_ram_wdata", 64'(ram_wdata), 0);
    chk("rst_cmd_ready", 64'(cmd_ready), 1);
    mon_en = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    write_burst(5, 3, -1, 0);
    read_burst(5, 3, 0);
    write_burst(62, 4, -1, 0);
    read_burst(62, 4, 0);
    read_burst(5, 2, 5);
    write_burst(30, 4, 2, 2);
    read_burst(30, 4, 0);

    // zero-length commands
    nw = n_writes; nr = n_reads; dc = done_cnt;
    do_cmd(1'b1, 3, 0);
    @(negedge clk);
    chk("len0_done", 64'(done), 1);
    chk("len0_busy", 64'(busy), 0);
    chk("len0_ready", 64'(cmd_ready), 1);
    @(posedge clk); #1;
    do_cmd(1'b0, 3, 0);
    repeat (4) @(negedge clk);
    chk("len0_done_cnt", 64'(done_cnt - dc), 2);
    chk("len0_no_ram", 64'((n_writes - nw) + (n_reads - nr)), 0);
    @(posedge clk); #1;

    // reset during beat 2 of a 4-beat write
    d0 = $urandom; d1 = $urandom;
    exp_wa.push_back(10); exp_wd.push_back(d0); shadow[10] = d0;
    nw = n_writes; dc = done_cnt;
    do_cmd(1'b1, 10, 4);
    wr_valid = 1'b1; wr_data = d0;
    @(posedge clk); #1;
    rst_n = 1'b0; wr_data = d1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_cs", 64'(ram_cs), 0);
    chk("mid_rst_we", 64'(ram_we), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1; wr_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_writes", 64'(n_writes - nw), 1);
    chk("mid_rst_no_done", 64'(done_cnt - dc), 0);
    chk("mid_rst_ready", 64'(cmd_ready), 1);
    @(posedge clk); #1;
    write_burst(20, 2, -1, 0);
    read_burst(10, 1, 0);
    read_burst(20, 2, 0);

    chk("wr_sb_empty", 64'(exp_wa.size()), 0);
    chk("rd_sb_empty", 64'(exp_rd.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: RAM address width.
REQ-002 Parameter DATA_WIDTH, default 32: RAM data width.
REQ-003 Parameter DEPTH, default 64: RAM word count; addresses run 0..DEPTH-1.
REQ-004 Parameter LEN_WIDTH, default 7: burst length width; maximum length DEPTH.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  start address
cmd_len  in  LEN_WIDTH  beat count, 0..DEPTH
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat accepted when high with wr_valid
wr_data  in  DATA_WIDTH  write beat data
rd_valid  out  1  read beat available
rd_ready  in  1  read beat consumed when high with rd_valid
rd_data  out  DATA_WIDTH  read beat data
busy  out  1  command in progress
done  out  1  one-cycle burst-complete pulse
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_oe  out  1  RAM output enable
ram_rdata  in  DATA_WIDTH  RAM read data; valid one cycle after a read cycle; Z when not driven

Function
REQ-006 Every output SHALL be driven from a register except cmd_ready (state==IDLE) and wr_ready (state==WR).
REQ-007 States: IDLE, WR, WR_END, RD_ADDR, RD_CAP, RD_OUT.
REQ-008 IDLE: on cmd_valid, latch cmd_addr and cmd_len; go to WR if cmd_write=1, else RD_ADDR; busy=1 from the next cycle.
REQ-009 A command with cmd_len=0 SHALL perform no RAM access and no data handshake; done pulses the next cycle; state stays IDLE.
REQ-010 WR: each wr_valid&wr_ready beat SHALL drive ram_cs=1, ram_we=1, ram_oe=0, ram_addr=current address, ram_wdata=wr_data for exactly the next cycle, then advance the address. Back-to-back beats give one RAM write per cycle.
REQ-011 WR with wr_valid=0 SHALL drive ram_cs=0 and ram_we=0 in the next cycle; no write occurs.
REQ-012 Acceptance of the last beat SHALL move to WR_END; WR_END holds that last write on the RAM pins, pulses done, then returns to IDLE.
REQ-013 RD_ADDR: pins ram_cs=1, ram_we=0, ram_oe=1, ram_addr=current address in the next cycle; go to RD_CAP.
REQ-014 RD_CAP: hold the same pins for one more cycle; capture ram_rdata into rd_data at the end of that cycle; rd_valid=1 from the following cycle; go to RD_OUT.
REQ-015 RD_OUT: ram_cs=0, ram_oe=0; hold rd_data and rd_valid stable until rd_ready. On handshake, clear rd_valid, advance the address, and go to RD_ADDR if beats remain; otherwise pulse done and go to IDLE.
REQ-016 Read throughput SHALL be one beat per 3 cycles minimum; read latency SHALL be 3 cycles from command acceptance to rd_valid.
REQ-017 The address SHALL increment by 1 per beat and wrap from DEPTH-1 to 0.
REQ-018 ram_we=1 SHALL never coincide with ram_oe=1.
REQ-019 done SHALL be high exactly one cycle per accepted command; busy SHALL fall in the done cycle.
REQ-020 cmd_valid SHALL be ignored outside IDLE. wr_valid SHALL be ignored outside WR. rd_ready SHALL be ignored outside RD_OUT.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, rd_valid=0, rd_data=0, ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0, ram_wdata=0 from the next cycle.
REQ-022 Reset mid-burst SHALL abandon the burst without a done pulse, and no RAM write SHALL occur in the cycle after reset.

Verification
REQ-023 Write cmd addr=5 len=3, wr_valid held high with data A,B,C -> RAM write pins show (5,A),(6,B),(7,C) on consecutive cycles; done one cycle later.
REQ-024 Read cmd addr=5 len=3 after REQ-023, rd_ready=1 -> rd_data A,B,C, each rd_valid 3 cycles apart; first rd_valid 3 cycles after acceptance; then done.
REQ-025 Write cmd addr=62 len=4 -> writes to addresses 62,63,0,1; readback returns the same data in order.
REQ-026 Read beat with rd_ready low for 5 cycles -> rd_valid and rd_data stable; ram_cs=0 throughout the stall; no extra RAM read.
REQ-027 Write burst with a wr_valid gap of 2 cycles -> ram_cs=0 for 2 cycles; written data correct; cmd_len=0 -> done next cycle with no ram_cs.
REQ-028 rst_n low during beat 2 of a 4-beat write -> no further writes; no done; cmd_ready=1 after reset; a new command executes normally.
